// File: rtl/hit_judge_pkg.sv
// Shared types and constants for the whack-a-mole scoring stage.
package hit_judge_pkg;

  // Game-control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // Width of one BCD digit and its largest value
  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;

endpackage : hit_judge_pkg

// File: rtl/hit_judge_if.sv
// Bundle between the button/mole stages and the hit judge.
// Handshake: there is no valid/ready pair. Every input is either a
// one-cycle pulse (start, tick_1hz, press) or a level (mole_up).
// The outputs hit, miss and hit_clear are one-cycle pulses. The other
// outputs are levels that hold until the next state change.
interface hit_judge_if
  import hit_judge_pkg::*;
#(
  parameter int NUM_HOLES    = 8,
  parameter int SCORE_DIGITS = 4
);
  logic                          start;
  logic                          tick_1hz;
  logic [NUM_HOLES-1:0]          press;
  logic [NUM_HOLES-1:0]          mole_up;
  logic [NUM_HOLES-1:0]          hit_clear;
  logic                          hit;
  logic                          miss;
  logic [BCD_W*SCORE_DIGITS-1:0] score_bcd;
  logic [7:0]                    time_left;
  logic [3:0]                    misses;
  logic                          playing;
  logic                          game_over;
  state_e                        state;     // debug view of the FSM

  // Input side: button, timer and mole generator stages
  modport master (
    output start, tick_1hz, press, mole_up,
    input  hit_clear, hit, miss, score_bcd, time_left, misses,
           playing, game_over, state
  );

  // Judge side
  modport slave (
    input  start, tick_1hz, press, mole_up,
    output hit_clear, hit, miss, score_bcd, time_left, misses,
           playing, game_over, state
  );
endinterface : hit_judge_if

// File: rtl/hit_judge_bcd_counter.sv
// Saturating multi-digit BCD incrementer with a synchronous clear.
module hit_judge_bcd_counter
  import hit_judge_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    inc,
  output logic [BCD_W*DIGITS-1:0] value
);

  logic [BCD_W*DIGITS-1:0] value_q, value_d;
  logic                    all_nine;
  logic                    carry;

  // Ripple a decimal carry up from digit 0; hold once every digit is 9
  always_comb begin
    all_nine = 1'b1;
    carry    = 1'b0;
    value_d  = value_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (value_q[i*BCD_W +: BCD_W] != BCD_NINE) all_nine = 1'b0;
    end
    if (clr) begin
      value_d = '0;
    end else if (inc && !all_nine) begin
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (value_q[i*BCD_W +: BCD_W] == BCD_NINE) begin
            value_d[i*BCD_W +: BCD_W] = '0;
          end else begin
            value_d[i*BCD_W +: BCD_W] = value_q[i*BCD_W +: BCD_W] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Score register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule : hit_judge_bcd_counter

// File: rtl/hit_judge.sv
// Classifies presses as hits or misses. It also keeps the score, the
// countdown and the miss count, and runs the IDLE/PLAY/OVER game FSM.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int NUM_HOLES    = 8,
  parameter int SCORE_DIGITS = 4,
  parameter int GAME_SECONDS = 60,
  parameter int MAX_MISSES   = 3
) (
  input logic          clk,
  input logic          rst_n,
  hit_judge_if.slave   bus
);

  localparam logic [7:0] TIME_RELOAD = 8'(GAME_SECONDS);
  localparam logic [3:0] MISS_LIMIT  = 4'(MAX_MISSES);

  state_e               state_q, state_d;
  logic [7:0]           time_q, time_d;
  logic [3:0]           misses_q, misses_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic [NUM_HOLES-1:0] hit_clear_q, hit_clear_d;
  logic [NUM_HOLES-1:0] hit_set, miss_set;
  logic                 score_clr, score_inc;
  logic [BCD_W*SCORE_DIGITS-1:0] score;

  assign hit_set  = bus.press & bus.mole_up;
  assign miss_set = bus.press & ~bus.mole_up;

  // Next-state, counter and pulse logic; a hit always suppresses a miss
  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    misses_d    = misses_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    hit_clear_d = '0;
    score_clr   = 1'b0;
    score_inc   = 1'b0;
    case (state_q)
      ST_PLAY: begin
        if (|hit_set) begin
          hit_d       = 1'b1;
          hit_clear_d = hit_set;
          score_inc   = 1'b1;
        end else if (|miss_set) begin
          miss_d = 1'b1;
          if (misses_q != 4'd15) misses_d = misses_q + 4'd1;
        end
        if (bus.tick_1hz && (time_q != 8'd0)) time_d = time_q - 8'd1;
        // Ends on the same edge that updates the terminating counter
        if ((time_d == 8'd0) ||
            ((MISS_LIMIT != 4'd0) && (misses_d >= MISS_LIMIT))) begin
          state_d = ST_OVER;
        end
      end
      default: begin
        // IDLE and OVER: only start matters
        if (bus.start) begin
          state_d   = ST_PLAY;
          time_d    = TIME_RELOAD;
          misses_d  = 4'd0;
          score_clr = 1'b1;
        end
      end
    endcase
  end

  // FSM state and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      time_q      <= TIME_RELOAD;
      misses_q    <= 4'd0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      hit_clear_q <= '0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      misses_q    <= misses_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      hit_clear_q <= hit_clear_d;
    end
  end

  hit_judge_bcd_counter #(
    .DIGITS (SCORE_DIGITS)
  ) u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (score_clr),
    .inc   (score_inc),
    .value (score)
  );

  assign bus.hit_clear = hit_clear_q;
  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;
  assign bus.score_bcd = score;
  assign bus.time_left = time_q;
  assign bus.misses    = misses_q;
  assign bus.playing   = (state_q == ST_PLAY);
  assign bus.game_over = (state_q == ST_OVER);
  assign bus.state     = state_q;

endmodule : hit_judge

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: one default-sized instance plus one
// with a two-second game for the countdown cases.
module tb_hit_judge;
  import hit_judge_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hit_judge_if #(.NUM_HOLES(8), .SCORE_DIGITS(4)) bus0 ();
  hit_judge_if #(.NUM_HOLES(8), .SCORE_DIGITS(4)) bus1 ();

  hit_judge #(.NUM_HOLES(8), .SCORE_DIGITS(4), .GAME_SECONDS(60), .MAX_MISSES(3))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus0));

  hit_judge #(.NUM_HOLES(8), .SCORE_DIGITS(4), .GAME_SECONDS(2), .MAX_MISSES(3))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // ---------------- scoreboard counters ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle press on bus0, followed by an idle cycle
  task automatic hit_once(input logic [7:0] p);
    bus0.press = p;
    step();
    bus0.press = '0;
    step();
  endtask

  task automatic start0();
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus0.start = 1'b0; bus0.tick_1hz = 1'b0; bus0.press = '0; bus0.mole_up = '0;
    bus1.start = 1'b0; bus1.tick_1hz = 1'b0; bus1.press = '0; bus1.mole_up = '0;

    // Reset values
    #23;
    chk("rst_score",   32'(bus0.score_bcd), 32'h0000);
    chk("rst_time",    32'(bus0.time_left), 32'd60);
    chk("rst_time2",   32'(bus1.time_left), 32'd2);
    chk("rst_misses",  32'(bus0.misses),    32'd0);
    chk("rst_playing", 32'(bus0.playing),   32'd0);
    chk("rst_over",    32'(bus0.game_over), 32'd0);
    chk("rst_hit",     32'(bus0.hit),       32'd0);
    chk("rst_miss",    32'(bus0.miss),      32'd0);
    chk("rst_clear",   32'(bus0.hit_clear), 32'd0);
    chk("rst_state",   32'(bus0.state),     32'(ST_IDLE));
    rst_n = 1'b1;
    step();

    // Press in IDLE is ignored
    bus0.mole_up = 8'h04; bus0.press = 8'h04;
    step();
    bus0.press = '0;
    chk("idle_press_hit", 32'(bus0.hit), 32'd0);

    // ---- Countdown on the 2-second instance, hit on the final tick ----
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    chk("g2_playing", 32'(bus1.playing),   32'd1);
    chk("g2_time2",   32'(bus1.time_left), 32'd2);
    bus1.tick_1hz = 1'b1;
    step();
    bus1.tick_1hz = 1'b0;
    chk("g2_time1",   32'(bus1.time_left), 32'd1);
    chk("g2_still",   32'(bus1.playing),   32'd1);
    bus1.tick_1hz = 1'b1; bus1.mole_up = 8'h20; bus1.press = 8'h20;
    step();
    bus1.tick_1hz = 1'b0; bus1.press = '0;
    chk("g2_time0",   32'(bus1.time_left), 32'd0);
    chk("g2_hit",     32'(bus1.hit),       32'd1);
    chk("g2_score",   32'(bus1.score_bcd), 32'h0001);
    chk("g2_over",    32'(bus1.game_over), 32'd1);
    chk("g2_noplay",  32'(bus1.playing),   32'd0);

    // ---- Basic hit ----
    start0();
    chk("start_playing", 32'(bus0.playing),   32'd1);
    chk("start_time",    32'(bus0.time_left), 32'd60);
    bus0.mole_up = 8'h04; bus0.press = 8'h04;
    step();
    bus0.press = '0;
    chk("hit1_hit",   32'(bus0.hit),       32'd1);
    chk("hit1_clear", 32'(bus0.hit_clear), 32'h04);
    chk("hit1_score", 32'(bus0.score_bcd), 32'h0001);
    chk("hit1_miss",  32'(bus0.miss),      32'd0);
    step();
    chk("hit1_pulse_end", 32'(bus0.hit),       32'd0);
    chk("hit1_clear_end", 32'(bus0.hit_clear), 32'h00);

    // ---- Mixed press: hit wins, miss discarded ----
    bus0.mole_up = 8'h03; bus0.press = 8'h07;
    step();
    bus0.press = '0;
    chk("mix_hit",    32'(bus0.hit),       32'd1);
    chk("mix_clear",  32'(bus0.hit_clear), 32'h03);
    chk("mix_score",  32'(bus0.score_bcd), 32'h0002);
    chk("mix_miss",   32'(bus0.miss),      32'd0);
    chk("mix_misses", 32'(bus0.misses),    32'd0);
    step();

    // ---- Countdown tick ----
    bus0.tick_1hz = 1'b1;
    step();
    bus0.tick_1hz = 1'b0;
    chk("tick_time", 32'(bus0.time_left), 32'd59);

    // ---- Decimal carry 0099 -> 0100 ----
    bus0.mole_up = 8'h01;
    for (int i = 0; i < 97; i++) hit_once(8'h01);
    chk("pre_carry", 32'(bus0.score_bcd), 32'h0099);
    bus0.press = 8'h01;
    step();
    bus0.press = '0;
    chk("carry_score", 32'(bus0.score_bcd), 32'h0100);
    step();

    // ---- Saturation at 9999 ----
    for (int i = 0; i < 9899; i++) hit_once(8'h01);
    chk("pre_sat", 32'(bus0.score_bcd), 32'h9999);
    bus0.press = 8'h01;
    step();
    bus0.press = '0;
    chk("sat_hit",   32'(bus0.hit),       32'd1);
    chk("sat_clear", 32'(bus0.hit_clear), 32'h01);
    chk("sat_score", 32'(bus0.score_bcd), 32'h9999);
    step();

    // ---- Miss limit ----
    bus0.mole_up = 8'h00;
    for (int i = 1; i <= 3; i++) begin
      bus0.press = 8'h10;
      step();
      bus0.press = '0;
      chk("miss_pulse",  32'(bus0.miss),   32'd1);
      chk("miss_nohit",  32'(bus0.hit),    32'd0);
      chk("miss_count",  32'(bus0.misses), 32'(i));
      chk("miss_over",   32'(bus0.game_over), (i == 3) ? 32'd1 : 32'd0);
      step();
      chk("miss_pulse_end", 32'(bus0.miss), 32'd0);
    end
    chk("over_playing", 32'(bus0.playing), 32'd0);
    chk("over_state",   32'(bus0.state),   32'(ST_OVER));
    bus0.press = 8'h10; bus0.tick_1hz = 1'b1;
    step();
    bus0.press = '0; bus0.tick_1hz = 1'b0;
    chk("over_miss",   32'(bus0.miss),      32'd0);
    chk("over_hit",    32'(bus0.hit),       32'd0);
    chk("over_misses", 32'(bus0.misses),    32'd3);
    chk("over_time",   32'(bus0.time_left), 32'd59);
    chk("over_score",  32'(bus0.score_bcd), 32'h9999);

    // ---- Restart from OVER ----
    start0();
    chk("restart_play",   32'(bus0.playing),   32'd1);
    chk("restart_score",  32'(bus0.score_bcd), 32'h0000);
    chk("restart_misses", 32'(bus0.misses),    32'd0);
    chk("restart_time",   32'(bus0.time_left), 32'd60);

    // ---- start in PLAY ignored; reach score 5 ----
    bus0.mole_up = 8'h80;
    for (int i = 0; i < 5; i++) hit_once(8'h80);
    start0();
    chk("play_start_ign", 32'(bus0.score_bcd), 32'h0005);

    // ---- Asynchronous reset mid-game ----
    rst_n = 1'b0;
    #2;
    chk("arst_score",   32'(bus0.score_bcd), 32'h0000);
    chk("arst_time",    32'(bus0.time_left), 32'd60);
    chk("arst_playing", 32'(bus0.playing),   32'd0);
    chk("arst_state",   32'(bus0.state),     32'(ST_IDLE));
    #2;
    rst_n = 1'b1;
    bus0.press = 8'h80; bus0.tick_1hz = 1'b1;
    step();
    bus0.press = '0; bus0.tick_1hz = 1'b0;
    chk("post_rst_hit",  32'(bus0.hit),       32'd0);
    chk("post_rst_time", 32'(bus0.time_left), 32'd60);
    chk("post_rst_idle", 32'(bus0.playing),   32'd0);
    start0();
    bus0.press = 8'h80;
    step();
    bus0.press = '0;
    chk("fresh_score", 32'(bus0.score_bcd), 32'h0001);
    chk("fresh_play",  32'(bus0.playing),   32'd1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_hit_judge

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Scoring and game-control stage fed by NUM_HOLES debounced press pulses, one per hole. Each pulse lasts one clk cycle.
- Each press is compared against the mole-visibility mask from the mole generator. The block classifies it as a hit or a miss.
- On a hit the block clears the mole and advances a BCD score. It also runs the game countdown and the miss limit.
- Outputs drive the 7-segment display and the mole generator.

Parameters:
- NUM_HOLES, 8, number of holes/buttons; range 1..16
- SCORE_DIGITS, 4, BCD digits of score
- GAME_SECONDS, 60, countdown reload value; range 1..255
- MAX_MISSES, 3, misses that end the game; 0 disables the miss limit; range 0..15

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse from the start button stage
- tick_1hz  in  1  one-cycle enable pulse, once per second
- press  in  NUM_HOLES  one-cycle press pulses, bit i = hole i
- mole_up  in  NUM_HOLES  level, bit i high while mole i is visible
- hit_clear  out  NUM_HOLES  one-cycle pulse, tells the mole generator to drop mole i
- hit  out  1  one-cycle pulse per scoring cycle
- miss  out  1  one-cycle pulse per miss cycle
- score_bcd  out  4*SCORE_DIGITS  BCD score; digit 0 in bits [3:0]
- time_left  out  8  seconds remaining
- misses  out  4  miss count
- playing  out  1  high in PLAY
- game_over  out  1  high in OVER

Behaviour:
- States: IDLE, PLAY, OVER. Reset enters IDLE.
- Reset values: all outputs 0, except time_left = GAME_SECONDS.
- Reset asserted mid-game aborts immediately to IDLE with the reset values.

State transitions:
- IDLE --start--> PLAY.
- OVER --start--> PLAY.
- On entering PLAY: score = 0, misses = 0, time_left = GAME_SECONDS. All are loaded in the same cycle the start pulse is sampled.
- start in PLAY is ignored.
- PLAY -> OVER when time_left reaches 0, or when MAX_MISSES != 0 and misses reaches MAX_MISSES.
- The transition takes effect on the same edge that updates the terminating counter.

Press processing (PLAY only; press is ignored in IDLE and OVER):
- Compute hit_set = press & mole_up and miss_set = press & ~mole_up, sampled in cycle N.
- If hit_set != 0:
  - hit = 1 and hit_clear = hit_set in cycle N+1.
  - score += 1, exactly once regardless of popcount.
  - miss_set is discarded that cycle.
- Else if miss_set != 0:
  - miss = 1 in cycle N+1.
  - misses += 1, saturating at 15.
- Outputs are registered, so latency is one cycle. All pulses last exactly one cycle.

Score:
- Decimal ripple-carry increment across digits.
- Saturates at all-9s: further hits still pulse hit and hit_clear but leave the score unchanged.

Countdown:
- On tick_1hz in PLAY with time_left > 0, time_left decrements.
- tick_1hz in IDLE or OVER has no effect.

Simultaneous events:
- tick and press in the same cycle: both are applied. A hit on the final second scores, then the game enters OVER.
- A hit that arrives in the same cycle the miss limit is reached cannot happen, because a hit suppresses the miss.

OVER:
- score, misses and time_left hold.
- game_over = 1, playing = 0.

Decomposition:
- Shared package holds the state enum (IDLE, PLAY, OVER) and a BCD digit-width constant (4). It also holds a BCD_NINE constant.
- One sub-module, bcd_counter: an SCORE_DIGITS-wide saturating BCD incrementer with inc and clr inputs. It is instantiated once for the score.

Test Plan:
- Reset, then start; mole_up = 8'h04; press = 8'h04 for one cycle -> next cycle hit = 1, hit_clear = 8'h04, score_bcd = 16'h0001; miss stays 0.
- PLAY, mole_up = 8'h00, press = 8'h10, repeated 3 times -> miss pulses 3 times, misses = 3, then game_over = 1 and playing = 0. A further press gives no pulses.
- GAME_SECONDS = 2; start, then 2 tick_1hz pulses -> time_left goes 2, 1, 0 and the state is OVER. A hit in the same cycle as the second tick still yields score = 1.
- mole_up = 8'h03 and press = 8'h07 in one cycle -> hit = 1, hit_clear = 8'h03, score +1, miss = 0, misses unchanged.
- Preload the score to 9999 (via 9999 hits, or by forcing the value) and hit again -> hit pulses, score_bcd stays 16'h9999. Also check the carry case: 0099 -> 0100.
- Assert rst_n low mid-PLAY with score = 5 -> all outputs are reset values immediately. With rst_n high, start and press are ignored until the next start, which begins a fresh game from IDLE.
